// File: rtl/sys_feeder.sv
// Edge feeder and job sequencer for an N x N multiply-accumulate systolic array.
// It accepts one operand slice per handshake, skews lane i by i cycles and pulses done once every PE result is final.
module sys_feeder #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            array_clr,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] left_out,
  output logic [N*DW-1:0] up_out
);

  localparam int DCW = $clog2(2 * N + 1);
  // Done is raised from count 2N-2 so that it is visible in the cycle where the count reaches 2N-1.
  localparam logic [DCW-1:0] DONE_ARM = DCW'(2 * N - 2);
  localparam logic [DCW-1:0] DONE_END = DCW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  state_t          state;
  logic [KW-1:0]   k_lat;
  logic [KW-1:0]   slice_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic            xfer;

  assign xfer = in_valid & in_ready;

  // NOTE: every register in this block uses <= so that each branch reads the pre-edge values of
  // state and the counters, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      array_clr <= 1'b0;
      in_ready  <= 1'b0;
      k_lat     <= '0;
      slice_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      array_clr <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_lat     <= k_len;
            slice_cnt <= '0;
            busy      <= 1'b1;
            array_clr <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (k_lat == '0) begin
            drain_cnt <= DONE_END;
            done      <= 1'b1;
            state     <= DRAIN;
          end else begin
            in_ready <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            slice_cnt <= slice_cnt + 1'b1;
            if (slice_cnt == k_lat - 1'b1) begin
              in_ready  <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DONE_END) begin
            busy      <= 1'b0;
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            if (drain_cnt == DONE_ARM) done <= 1'b1;
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i is i+1 registers deep. Bubbles carry zeros, which add nothing to the accumulators.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_sr [i+1];
    logic [DW-1:0] b_sr [i+1];

    // NOTE: the skew chains are reset element by element; unlike a RAM they drive the array
    // directly, and stale operands after a reset would corrupt the next job.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= xfer ? a_vec[i*DW +: DW] : '0;
        b_sr[0] <= xfer ? b_vec[i*DW +: DW] : '0;
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign left_out[i*DW +: DW] = a_sr[i];
    assign up_out[i*DW +: DW]   = b_sr[i];
  end

endmodule
